pc_fetch_ctrl: RTL and testbench

- Fetch-stage PC and instruction-memory controller for the r200 core.
- Sits directly upstream of the ID-stage jump target generator: it supplies the fetched instruction `instrn` and its `pc` to ID.
- It consumes ID's `immediate` and `addtoimm` outputs and forms the JAL/JALR target. On a taken jump it redirects fetch and discards wrong-path responses.
- Single outstanding memory request, one-entry output register, one-entry hold buffer.

---
 rtl/r200_pkg.sv | 11 +
 rtl/pc_target_adder.sv | 11 +
 rtl/pc_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r200_pkg.sv
// Shared r200 core constants and the fetch controller state encoding.
package r200_pkg;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/pc_target_adder.sv
// JAL/JALR target: (addtoimm + immediate) with bit 0 cleared, carry out dropped.
// Combinational; misaligned flags a target that is not 4-byte aligned.
module pc_target_adder (
   input  logic [31:0] addtoimm,
   input  logic [31:0] immediate,
   output logic [31:0] tgt,
   output logic        misaligned
);
   assign tgt        = (addtoimm + immediate) & ~32'h1;
   assign misaligned = tgt[1];
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC / imem controller: one outstanding request, output register plus one-entry hold buffer.
// gnt->rvalid->instrn_valid takes 2 cycles; id_ready low fills the hold buffer and then stops requesting.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = r200_pkg::DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = r200_pkg::DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] immediate,
   input  logic [31:0] addtoimm,
   input  logic        jump_valid,
   input  logic        id_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrn,
   output logic [31:0] pc,
   output logic        instrn_valid,
   output logic        jump_misaligned
);
   import r200_pkg::*;

   fetch_state_t state, state_nxt;
   logic [31:0]  fetch_pc, fetch_pc_nxt;
   logic [31:0]  req_pc, req_pc_nxt;
   logic         drop, drop_nxt;
   logic [31:0]  hold_instr, hold_pc;
   logic         hold_wr;
   logic         out_ld;
   logic [31:0]  out_dat, out_pc;

   logic [31:0]  tgt;
   logic         tgt_mis;
   logic         consume, jump_take, redirect;

   pc_target_adder u_tgt (
      .addtoimm   (addtoimm),
      .immediate  (immediate),
      .tgt        (tgt),
      .misaligned (tgt_mis)
   );

   // The jump instruction is consumed in the same cycle it redirects.
   assign consume   = instrn_valid & id_ready;
   assign jump_take = consume & jump_valid;
   assign redirect  = jump_take & ~tgt_mis;

   assign imem_req  = rst_n & (state == REQ);
   assign imem_addr = fetch_pc;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_pc_nxt   = req_pc;
      drop_nxt     = drop;
      hold_wr      = 1'b0;
      out_ld       = 1'b0;
      out_dat      = imem_rdata;
      out_pc       = req_pc;
      unique case (state)
         REQ: begin
            if (imem_gnt) begin
               state_nxt  = WAIT;
               req_pc_nxt = fetch_pc;
               drop_nxt   = redirect;
            end
            if (redirect) fetch_pc_nxt = tgt;
         end
         WAIT: begin
            if (imem_rvalid) begin
               drop_nxt  = 1'b0;
               state_nxt = REQ;
               if (redirect) begin
                  fetch_pc_nxt = tgt;
               end else if (!drop) begin
                  fetch_pc_nxt = fetch_pc + 32'd4;
                  if (!instrn_valid || id_ready) begin
                     out_ld = 1'b1;
                  end else begin
                     hold_wr   = 1'b1;
                     state_nxt = HOLD;
                  end
               end
            end else if (redirect) begin
               // Response still in flight: remember to discard it.
               drop_nxt     = 1'b1;
               fetch_pc_nxt = tgt;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_nxt    = REQ;
               fetch_pc_nxt = tgt;
            end else if (id_ready) begin
               state_nxt = REQ;
               out_ld    = 1'b1;
               out_dat   = hold_instr;
               out_pc    = hold_pc;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= REQ;
         fetch_pc        <= RESET_PC;
         req_pc          <= RESET_PC;
         drop            <= 1'b0;
         hold_instr      <= NOP_INSTR;
         hold_pc         <= 32'h0;
         instrn          <= NOP_INSTR;
         pc              <= 32'h0;
         instrn_valid    <= 1'b0;
         jump_misaligned <= 1'b0;
      end else begin
         state           <= state_nxt;
         fetch_pc        <= fetch_pc_nxt;
         req_pc          <= req_pc_nxt;
         drop            <= drop_nxt;
         jump_misaligned <= jump_take & tgt_mis;
         if (hold_wr) begin
            hold_instr <= imem_rdata;
            hold_pc    <= req_pc;
         end
         if (out_ld) begin
            instrn       <= out_dat;
            pc           <= out_pc;
            instrn_valid <= 1'b1;
         end else if (consume) begin
            instrn       <= NOP_INSTR;
            instrn_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: imem responder with random grant/latency, randomized ID side, in-order PC model.
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] immediate = '0, addtoimm = '0;
   logic        jump_valid = 1'b0, id_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instrn, pc;
   logic        instrn_valid, jump_misaligned;

   int checks = 0;
   int errors = 0;

   int gnt_pct = 100, rv_min = 1, rv_max = 1;
   bit spur_en = 1'b0;

   pc_fetch_ctrl #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .immediate(immediate), .addtoimm(addtoimm),
      .jump_valid(jump_valid), .id_ready(id_ready), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .instrn(instrn), .pc(pc),
      .instrn_valid(instrn_valid), .jump_misaligned(jump_misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Instruction memory: single outstanding read, response rv_min..rv_max cycles after grant.
   bit          pending = 1'b0, rv_now = 1'b0, req_q = 1'b0, gnt_q = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = '0, addr_q = '0;
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            pending = 1'b0;
         end else begin
            if (rv_now) pending = 1'b0;
            if (req_q && gnt_q) begin
               pending = 1'b1;
               paddr   = addr_q;
               cnt     = int'($urandom_range(rv_max, rv_min)) - 1;
            end else if (pending && cnt > 0) begin
               cnt--;
            end
         end
         #1;
         rv_now      = rst_n && pending && cnt == 0;
         imem_rvalid = rv_now || (!pending && spur_en && $urandom_range(0, 3) == 0);
         imem_rdata  = rv_now ? word(paddr) : 32'hDEAD_BEEF;
         imem_gnt    = imem_req && (int'($urandom_range(0, 99)) < gnt_pct);
         req_q       = imem_req;
         gnt_q       = imem_gnt;
         addr_q      = imem_addr;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; id_ready = 1'b0; jump_valid = 1'b0; addtoimm = '0; immediate = '0;
      gnt_pct = 100; rv_min = 1; rv_max = 1; spur_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = instrn_valid;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
      checks++; if (instrn_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", instrn_valid); end
      checks++; if (instrn !== NOP) begin errors++; $display("FAIL rst_instrn got %h want %h", instrn, NOP); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
      checks++; if (jump_misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis got %0b want 0", jump_misaligned); end
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL rst_release req %0b addr %h want 1 %h", imem_req, imem_addr, RPC); end
   endtask

   task automatic test_sequential();
      int nreq = 0, nv = 0;
      do_reset();
      id_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (imem_req) begin
            checks++;
            if (imem_addr !== RPC + 32'(4 * nreq)) begin
               errors++; $display("FAIL seq_addr got %h want %h", imem_addr, RPC + 32'(4 * nreq)); end
            nreq++;
         end
         if (instrn_valid) begin
            checks++;
            if (pc !== RPC + 32'(4 * nv) || instrn !== word(RPC + 32'(4 * nv)) || c != 2 + 2 * nv) begin
               errors++; $display("FAIL seq_out cycle %0d pc %h instrn %h want cycle %0d pc %h", c, pc, instrn, 2 + 2 * nv, RPC + 32'(4 * nv)); end
            nv++;
         end
      end
      checks++; if (nv < 4) begin errors++; $display("FAIL seq_count got %0d want >=4", nv); end
   endtask

   task automatic test_jalr();
      bit ok;
      do_reset();
      id_ready = 1'b1;
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL jalr_timeout got none want valid"); end
      jump_valid = 1'b1; addtoimm = 32'h1000; immediate = 32'h5;
      @(posedge clk); #1 jump_valid = 1'b0;
      @(negedge clk);
      checks++; if (imem_addr !== 32'h1004) begin errors++; $display("FAIL jalr_addr got %h want 00001004", imem_addr); end
      checks++; if (instrn_valid !== 1'b0) begin errors++; $display("FAIL jalr_clear got %0b want 0", instrn_valid); end
      wait_valid(ok);
      checks++; if (!ok || pc !== 32'h1004 || instrn !== word(32'h1004)) begin
         errors++; $display("FAIL jalr_next pc %h instrn %h want 00001004 %h", pc, instrn, word(32'h1004)); end
   endtask

   task automatic test_misaligned();
      bit ok;
      do_reset();
      id_ready = 1'b1;
      wait_valid(ok);
      jump_valid = 1'b1; addtoimm = 32'h1000; immediate = 32'h2;
      @(posedge clk); #1 jump_valid = 1'b0;
      @(negedge clk);
      checks++; if (jump_misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse got %0b want 1", jump_misaligned); end
      checks++; if (imem_addr !== RPC + 32'h4) begin errors++; $display("FAIL mis_noredir got %h want %h", imem_addr, RPC + 32'h4); end
      @(negedge clk);
      checks++; if (jump_misaligned !== 1'b0) begin errors++; $display("FAIL mis_width got %0b want 0", jump_misaligned); end
      checks++; if (!instrn_valid || pc !== RPC + 32'h4 || imem_addr !== RPC + 32'h8) begin
         errors++; $display("FAIL mis_seq valid %0b pc %h addr %h want 1 %h %h", instrn_valid, pc, imem_addr, RPC + 32'h4, RPC + 32'h8); end
   endtask

   task automatic test_stall();
      bit ok;
      int n = 0;
      logic [31:0] exp = RPC;
      do_reset();
      id_ready = 1'b1;
      wait_valid(ok);
      for (int k = 0; k < 25; k++) begin
         if (k > 0) @(negedge clk);
         id_ready = (k >= 3);
         if (k == 2) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %0b want 0", imem_req); end
         end
         if (instrn_valid && id_ready) begin
            checks++;
            if (pc !== exp || instrn !== word(exp)) begin
               errors++; $display("FAIL stall_order pc %h instrn %h want %h", pc, instrn, exp); end
            exp += 32'd4;
            n++;
         end
      end
      checks++; if (n < 8) begin errors++; $display("FAIL stall_count got %0d want >=8", n); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      wait_valid(ok);
      @(negedge clk);
      // WAIT with the next response arriving this cycle; jump to 0x2000.
      id_ready = 1'b1; jump_valid = 1'b1; addtoimm = 32'h1FFC; immediate = 32'h4;
      @(posedge clk); #1 jump_valid = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
         errors++; $display("FAIL sim_rv_addr req %0b addr %h want 1 00002000", imem_req, imem_addr); end
      checks++; if (instrn_valid !== 1'b0 || instrn !== NOP) begin
         errors++; $display("FAIL sim_rv_clear valid %0b instrn %h want 0 %h", instrn_valid, instrn, NOP); end
      wait_valid(ok);
      checks++; if (!ok || pc !== 32'h2000) begin errors++; $display("FAIL sim_rv_next pc %h want 00002000", pc); end
      // Redirect in REQ while the grant for 0x2004 is given.
      jump_valid = 1'b1; addtoimm = 32'h3000; immediate = 32'h0;
      @(posedge clk); #1 jump_valid = 1'b0;
      wait_valid(ok);
      checks++; if (!ok || pc !== 32'h3000 || instrn !== word(32'h3000)) begin
         errors++; $display("FAIL sim_gnt_next pc %h instrn %h want 00003000", pc, instrn); end
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      do_reset();
      wait_valid(ok);
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || instrn_valid !== 1'b1) begin
         errors++; $display("FAIL rw_pre req %0b valid %0b want 0 1", imem_req, instrn_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (instrn_valid !== 1'b0 || instrn !== NOP || pc !== 32'h0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL rw_async valid %0b instrn %h pc %h req %0b want 0 %h 0 0", instrn_valid, instrn, pc, imem_req, NOP); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL rw_release req %0b addr %h want 1 %h", imem_req, imem_addr, RPC); end
      id_ready = 1'b1;
      wait_valid(ok);
      checks++; if (!ok || pc !== RPC || instrn !== word(RPC)) begin
         errors++; $display("FAIL rw_first pc %h instrn %h want %h", pc, instrn, RPC); end
   endtask

   // Model: the next instruction ID sees is pc+4 of the last one taken, or the aligned jump target.
   task automatic test_random();
      logic [31:0] exp_pc = RPC, exp_addr = '0, t;
      bit exp_mis = 1'b0, addr_chk = 1'b0, took;
      int ntaken = 0;
      do_reset();
      gnt_pct = 60; rv_min = 1; rv_max = 3; spur_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         id_ready   = $urandom_range(0, 9) < 7;
         jump_valid = $urandom_range(0, 99) < 15;
         if ($urandom_range(0, 19) == 0) begin
            addtoimm  = 32'hFFFF_FFF8;
            immediate = 32'h10 + 32'($urandom_range(0, 3));
         end else begin
            addtoimm  = 32'($urandom_range(0, 1023)) << 4;
            immediate = 32'($urandom_range(0, 15));
         end
         @(negedge clk);
         if (instrn_valid) begin
            checks++; if (pc !== exp_pc || instrn !== word(exp_pc)) begin
               errors++; $display("FAIL rnd_order pc %h instrn %h want %h %h", pc, instrn, exp_pc, word(exp_pc)); end
         end else begin
            checks++; if (instrn !== NOP) begin errors++; $display("FAIL rnd_nop got %h want %h", instrn, NOP); end
         end
         checks++; if (jump_misaligned !== exp_mis) begin
            errors++; $display("FAIL rnd_mis got %0b want %0b", jump_misaligned, exp_mis); end
         if (addr_chk) begin
            checks++; if (imem_addr !== exp_addr) begin
               errors++; $display("FAIL rnd_redir_addr got %h want %h", imem_addr, exp_addr); end
         end
         t        = (addtoimm + immediate) & ~32'h1;
         took     = instrn_valid && id_ready;
         exp_mis  = took && jump_valid && t[1];
         addr_chk = 1'b0;
         if (took) begin
            ntaken++;
            if (jump_valid && !t[1]) begin
               exp_pc = t; exp_addr = t; addr_chk = 1'b1;
            end else begin
               exp_pc += 32'd4;
            end
         end
      end
      checks++; if (ntaken < 150) begin errors++; $display("FAIL rnd_progress got %0d want >=150", ntaken); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jalr();
      test_misaligned();
      test_stall();
      test_simultaneous();
      test_reset_in_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
